// File: rtl/mul_seq_if.sv
// -----------------------------------------------------------------------------
// mul_seq_if : bundle of request, ALU and result signals for mul_seq.
//
// Signals:
//   start, op_a, op_b          multiply request and operands
//   alu_req, alu_op,
//   alu_in1, alu_in2           sequencer -> shared ALU
//   alu_out, alu_err           shared ALU -> sequencer (sum, overflow)
//   busy, stall, done          status / completion pulse
//   product, ovf               registered result and sticky overflow
//
// Modports:
//   slave  : the multiplier sequencer (mul_seq)
//   master : the surrounding system (requester plus shared ALU)
// -----------------------------------------------------------------------------
interface mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             alu_req;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_err;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             ovf;

    modport slave (
        input  start, op_a, op_b, alu_out, alu_err,
        output alu_req, alu_in1, alu_in2, alu_op,
        output busy, stall, done, product, ovf
    );

    modport master (
        output start, op_a, op_b, alu_out, alu_err,
        input  alu_req, alu_in1, alu_in2, alu_op,
        input  busy, stall, done, product, ovf
    );
endinterface

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq : sequential unsigned shift-add multiplier that borrows a shared ALU
// for every accumulate step.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   bus    mul_seq_if.slave (request, ALU bus, status, result)
//
// Operation: IDLE -> RUN (one multiplier bit per cycle) -> DONE -> IDLE/RUN.
// The done pulse, product and ovf are registered one cycle after the DONE
// state, so done appears WIDTH+1 cycles after the start edge.
//
// Build option: define MUL_SEQ_EARLY_TERM_EN to leave RUN as soon as no set
// multiplier bits remain; results are identical, only latency changes.
// -----------------------------------------------------------------------------
module mul_seq #(
    parameter int          WIDTH  = 16,
    parameter logic [3:0]  ADD_OP = 4'h0
) (
    input  logic     clk,
    input  logic     rst,
    mul_seq_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r,  state_nxt_s;
    logic [WIDTH-1:0] acc_r,    acc_nxt_s;
    logic [WIDTH-1:0] mcand_r,  mcand_nxt_s;
    logic [WIDTH-1:0] mplier_r, mplier_nxt_s;
    logic [CNT_W-1:0] count_r,  count_nxt_s;
    logic             ovf_acc_r, ovf_acc_nxt_s;
    logic [WIDTH-1:0] product_r;
    logic             ovf_r;
    logic             done_r;
    logic [WIDTH-1:0] mplier_shift_s;
    logic             last_s;
    logic             run_s;

    assign mplier_shift_s = {1'b0, mplier_r[WIDTH-1:1]};
    assign run_s          = (state_r == ST_RUN);

    // Decide whether the current RUN cycle is the final one.
    always_comb begin
`ifdef MUL_SEQ_EARLY_TERM_EN
        last_s = (count_r == CNT_W'(WIDTH - 1)) || (mplier_shift_s == {WIDTH{1'b0}});
`else
        last_s = (count_r == CNT_W'(WIDTH - 1));
`endif
    end

    // Next-state and datapath update for the shift-add sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        mcand_nxt_s   = mcand_r;
        mplier_nxt_s  = mplier_r;
        count_nxt_s   = count_r;
        ovf_acc_nxt_s = ovf_acc_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nxt_s   = ST_RUN;
                    mcand_nxt_s   = bus.op_a;
                    mplier_nxt_s  = bus.op_b;
                    acc_nxt_s     = {WIDTH{1'b0}};
                    count_nxt_s   = {CNT_W{1'b0}};
                    ovf_acc_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mplier_r[0]) begin
                    acc_nxt_s = bus.alu_out;
                end else begin
                    acc_nxt_s = acc_r;
                end
                // A carry out of the add, or a multiplicand bit lost while
                // higher multiplier bits remain, both mean the full product
                // no longer fits in WIDTH bits.
                ovf_acc_nxt_s = ovf_acc_r
                              | (mplier_r[0] & bus.alu_err)
                              | (mcand_r[WIDTH-1] & (|mplier_shift_s));
                mcand_nxt_s   = {mcand_r[WIDTH-2:0], 1'b0};
                mplier_nxt_s  = mplier_shift_s;
                count_nxt_s   = count_r + CNT_W'(1);
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            acc_r     <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            ovf_acc_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            mcand_r   <= mcand_nxt_s;
            mplier_r  <= mplier_nxt_s;
            count_r   <= count_nxt_s;
            ovf_acc_r <= ovf_acc_nxt_s;
        end
    end

    // Result registers: captured from the DONE state, held until the next result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r    <= 1'b0;
            product_r <= {WIDTH{1'b0}};
            ovf_r     <= 1'b0;
        end else if (state_r == ST_DONE) begin
            done_r    <= 1'b1;
            product_r <= acc_r;
            ovf_r     <= ovf_acc_r;
        end else begin
            done_r    <= 1'b0;
            product_r <= product_r;
            ovf_r     <= ovf_r;
        end
    end

    // ALU bus is owned only during RUN; otherwise it is parked at zero.
    always_comb begin
        if (run_s) begin
            bus.alu_req = 1'b1;
            bus.alu_op  = ADD_OP;
            bus.alu_in1 = acc_r;
            bus.alu_in2 = mcand_r;
        end else begin
            bus.alu_req = 1'b0;
            bus.alu_op  = 4'h0;
            bus.alu_in1 = {WIDTH{1'b0}};
            bus.alu_in2 = {WIDTH{1'b0}};
        end
    end

    // Status outputs; stall is gated by reset so it reads low while held in reset.
    always_comb begin
        bus.busy    = run_s;
        bus.stall   = rst & (run_s | (bus.start & ~run_s));
        bus.done    = done_r;
        bus.product = product_r;
        bus.ovf     = ovf_r;
    end
endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;
    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] prod;
        logic        ovf;
        int          lat;
        int          start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cycle_cnt = 0;
    int   done_cnt = 0;
    int   busy_acc = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mul_seq_if #(.WIDTH(WIDTH)) bus();

    mul_seq #(.WIDTH(WIDTH), .ADD_OP(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared ALU model: 16-bit add with carry-out as overflow.
    always_comb begin
        {bus.alu_err, bus.alu_out} = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;
    always @(negedge clk) if (bus.busy) busy_acc <= busy_acc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && bus.done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done product=%0h", bus.product);
            end else begin
                e = sb_q.pop_front();
                chk("product", {16'h0, bus.product}, {16'h0, e.prod});
                chk("ovf", {31'h0, bus.ovf}, {31'h0, e.ovf});
                chk("latency", cycle_cnt - e.start_cyc, e.lat);
            end
        end
    end

    // Drive a request for one sampling edge; optionally expect its result.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push,
                         input logic [15:0] prod, input logic ov,
                         input int lat_def, input int lat_early);
        exp_t e;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        e.prod = prod;
        e.ovf  = ov;
`ifdef MUL_SEQ_EARLY_TERM_EN
        e.lat  = lat_early;
`else
        e.lat  = lat_def;
`endif
        e.start_cyc = cycle_cnt + 1;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_count", done_cnt, target);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        exp_t e;
        rst = 1'b0;
        bus.start = 1'b1;
        bus.op_a = 16'h0;
        bus.op_b = 16'h0;
        #2;
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_alu_req", {31'h0, bus.alu_req}, 32'h0);
        chk("rst_alu_bus", {bus.alu_in1, bus.alu_in2}, 32'h0);
        chk("rst_alu_op", {28'h0, bus.alu_op}, 32'h0);
        chk("rst_result", {15'h0, bus.ovf, bus.product}, 32'h0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);

        // 3*5 issued on the very first edge after reset release.
        @(negedge clk);
        rst = 1'b1;
        base = busy_acc;
        issue(16'd3, 16'd5, 1'b1, 16'd15, 1'b0, 17, 4);
        @(negedge clk);
        chk("run_busy", {31'h0, bus.busy}, 32'h1);
        chk("run_stall", {31'h0, bus.stall}, 32'h1);
        chk("run_alu_req", {31'h0, bus.alu_req}, 32'h1);
        chk("run_alu_in", {bus.alu_in1, bus.alu_in2}, {16'h0, 16'h3});
        wait_done(1);
`ifdef MUL_SEQ_EARLY_TERM_EN
        chk("busy_cycles", busy_acc - base, 3);
`else
        chk("busy_cycles", busy_acc - base, 16);
`endif
        chk("idle_alu", {15'h0, bus.alu_req, bus.alu_in1 | bus.alu_in2}, 32'h0);
        chk("idle_status", {30'h0, bus.busy, bus.stall}, 32'h0);

        next_cycle();
        issue(16'd300, 16'd300, 1'b1, 16'h5F90, 1'b1, 17, 10);
        wait_done(2);

        // Zero multiplier; a second start during RUN must be ignored.
        next_cycle();
        issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0, 17, 2);
        bus.start = 1'b1;
        bus.op_a  = 16'd5;
        bus.op_b  = 16'd5;
        next_cycle();
        bus.start = 1'b0;
        wait_done(3);
        repeat (25) @(negedge clk);
        chk("single_done", done_cnt, 3);

        next_cycle();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 17, 17);
        wait_done(4);
        next_cycle();
        issue(16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b1, 17, 10);
        wait_done(5);
        next_cycle();
        issue(16'h0001, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 17, 17);
        wait_done(6);

        // Abort 7*9 with reset in RUN cycle 5; no done may follow.
        next_cycle();
        issue(16'd7, 16'd9, 1'b0, 16'd0, 1'b0, 0, 0);
        repeat (4) next_cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("abort_status", {29'h0, bus.done, bus.busy, bus.stall}, 32'h0);
        chk("abort_alu", {15'h0, bus.alu_req, bus.alu_in1 | bus.alu_in2}, 32'h0);
        chk("abort_result", {15'h0, bus.ovf, bus.product}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue(16'd7, 16'd9, 1'b1, 16'd63, 1'b0, 17, 5);
        wait_done(7);

        // Back-to-back: start held high, operands swapped in the DONE cycle.
        next_cycle();
        bus.start = 1'b1;
        bus.op_a  = 16'd2;
        bus.op_b  = 16'd2;
        e.prod = 16'd4;
        e.ovf = 1'b0;
`ifdef MUL_SEQ_EARLY_TERM_EN
        e.lat = 3;
`else
        e.lat = 17;
`endif
        e.start_cyc = cycle_cnt + 1;
        sb_q.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.busy && n < 40);
        do begin @(negedge clk); n++; end while (bus.busy && n < 40);
        chk("b2b_reach_done", {31'h0, bus.busy}, 32'h0);
        bus.op_a = 16'd4;
        bus.op_b = 16'd4;
        e.prod = 16'd16;
`ifdef MUL_SEQ_EARLY_TERM_EN
        e.lat = 4;
`else
        e.lat = 17;
`endif
        e.start_cyc = cycle_cnt + 1;
        sb_q.push_back(e);
        @(negedge clk);
        chk("b2b_no_idle", {31'h0, bus.busy}, 32'h1);
        next_cycle();
        bus.start = 1'b0;
        wait_done(9);
        repeat (5) @(negedge clk);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
